instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the single-cycle-issue KGP-style RISC core. Holds the fetch PC, requests instruction words from instruction memory over a req/ack handshake, and presents each fetched word with its PC (`ins`, `PC`) to the instruction decoder through a valid/ready handshake. It also applies branch/jump redirects from the execute stage and stops fetching permanently once a HALT instruction has been handed downstream.

## Interface
- `RESET_PC`, default 32'h0: first fetch address after reset.
- `PC_STEP`, default 1: increment per sequential fetch; instruction memory is word-addressed.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `imem_req`  out  1: fetch request; held high until `imem_ack`.
- `imem_addr`  out  32: fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1: memory response; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: instruction word.
- `ins`  out  32: instruction to the decoder.
- `PC`  out  32: address of `ins`.
- `ins_valid`  out  1: `ins`/`PC` valid.
- `ins_ready`  in  1: decoder accepts; transfer occurs when `ins_valid && ins_ready`.
- `redirect_en`  in  1: one-cycle redirect pulse from the branch unit.
- `redirect_pc`  in  32: redirect target.
- `halted`  out  1: a HALT has been delivered and fetch has stopped.

## Operation
- FSM states: IDLE, FETCH, HOLD, HALT.
- IDLE: entered on reset. Goes to FETCH on the first edge after `rst` falls.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - On `imem_ack` with no squash pending: latch `ins`<=`imem_rdata`, `PC`<=`fetch_pc`, then go to HOLD.
- HOLD: `ins_valid`=1.
  - On transfer: if `ins[31:26]`==OPC_HALT (6'b100100), go to HALT. Otherwise set `fetch_pc`<=`PC`+`PC_STEP` and go to FETCH.
- HALT: `halted`=1, `imem_req`=0, `ins_valid`=0. The state is left only through reset.
- Redirect, in FETCH or HOLD: `fetch_pc`<=`redirect_pc`.
  - In HOLD: the held instruction is dropped (`ins_valid` falls next cycle) and the FSM goes to FETCH. Redirect beats `ins_ready` in the same cycle, so the transfer is void and a HALT held at that moment does not halt.
  - In FETCH without `imem_ack` that cycle: set `squash`. `imem_req`/`imem_addr` stay unchanged until ack. That ack's data is discarded, `squash` clears, and the next cycle requests `redirect_pc`.
  - In FETCH with `imem_ack` the same cycle: discard the data and request `redirect_pc` next cycle.
  - Redirect is ignored in IDLE and HALT.
- Arithmetic: `PC`+`PC_STEP` is 32-bit and wraps modulo 2^32 (32'hFFFFFFFF + 1 -> 0).

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `ins`=0, `PC`=0, `ins_valid`=0, `halted`=0, `squash`=0, `fetch_pc`=`RESET_PC`.
- Reset asserted mid-request: all state clears immediately. The outstanding ack is not tracked; memory must also be reset.
- `imem_req` rises on the first cycle after reset release.
- With same-cycle ack, `ins_valid` rises 1 cycle after `imem_req`.
- Best-case throughput is one instruction per 2 cycles. A new request issues the cycle after a transfer.
- Outputs `ins`, `PC`, `ins_valid` and `halted` are registered or pure state decodes. There are no combinational paths from `ins_ready` or `redirect_en` to outputs.

## Configuration
- `IFU_PERF_CNT_EN` defined: adds outputs `fetch_count` (out 32) and `stall_count` (out 32).
  - `fetch_count` increments on each transfer.
  - `stall_count` increments on each cycle with `ins_valid && !ins_ready`, or `imem_req && !imem_ack`.
  - Both counters reset to 0 and wrap.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `kgp_isa_pkg` holds the FSM state enum and `OPC_HALT` = 6'b100100, alongside the opcode constants the decoder uses.
- Optional sub-module `ifu_perf_counters` contains both counters. It is instantiated only under `IFU_PERF_CNT_EN`.

## Test plan
- Reset release, memory acks same cycle with word 32'h04210005, `ins_ready`=1:
  - `imem_req` rises cycle 1.
  - `ins_valid` rises cycle 2 with `PC`=0.
  - Next request uses `imem_addr`=1.
- Memory acks 3 cycles late, decoder holds `ins_ready`=0 for 4 cycles:
  - `imem_addr` stays stable until ack.
  - `ins`/`PC` stay stable while stalled.
  - No instruction is lost or duplicated.
- `redirect_en` with `redirect_pc`=32'h40 during an outstanding request:
  - The late-acked word is discarded.
  - The next `imem_addr`=32'h40.
  - The next delivered `PC`=32'h40.
- Redirect in the same cycle as a HALT transfer: `halted` stays 0 and fetch resumes at `redirect_pc`.
- HALT (32'h90000000) transferred:
  - `halted`=1 the next cycle.
  - `imem_req` stays 0 and redirects are ignored.
  - Reset clears `halted`.
- `redirect_pc`=32'hFFFFFFFF, then a transfer: next `imem_addr`=0 (wrap).

Source files
------------

// File: rtl/kgp_isa_pkg.sv
// rtl/kgp_isa_pkg.sv - shared KGP ISA opcode constants and fetch FSM state type
package kgp_isa_pkg;

   localparam logic [5:0] OPC_ALU   = 6'b000001;
   localparam logic [5:0] OPC_LOAD  = 6'b010000;
   localparam logic [5:0] OPC_STORE = 6'b010001;
   localparam logic [5:0] OPC_BR    = 6'b100000;
   localparam logic [5:0] OPC_HALT  = 6'b100100;

   typedef enum logic [1:0] {
      IFU_IDLE,
      IFU_FETCH,
      IFU_HOLD,
      IFU_HALT
   } ifu_state_e;

   function automatic logic is_halt(input logic [5:0] i_opc);
      return i_opc == OPC_HALT;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch stage bundle: imem req/ack, decoder valid/ready, redirect, halt
interface instr_fetch_unit_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ins;
   logic [31:0] PC;
   logic        ins_valid;
   logic        ins_ready;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        halted;

   modport master (
      output imem_req, imem_addr, ins, PC, ins_valid, halted,
      input  imem_ack, imem_rdata, ins_ready, redirect_en, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, ins, PC, ins_valid, halted,
      output imem_ack, imem_rdata, ins_ready, redirect_en, redirect_pc
   );

endinterface

// File: rtl/ifu_perf_counters.sv
// rtl/ifu_perf_counters.sv - wrapping transfer and stall counters for the fetch stage
module ifu_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_transfer,
   input  logic        i_stall,
   output logic [31:0] o_fetch_count,
   output logic [31:0] o_stall_count
);

   logic [31:0] r_fetch_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= 32'd0;
         r_stall_count <= 32'd0;
      end else begin
         if (i_transfer) r_fetch_count <= r_fetch_count + 32'd1;
         if (i_stall)    r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign o_fetch_count = r_fetch_count;
   assign o_stall_count = r_stall_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - KGP fetch stage: PC, imem req/ack, decoder handoff, redirect, halt
// IFU_PERF_CNT_EN adds fetch_count/stall_count outputs.
module instr_fetch_unit
   import kgp_isa_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic                clk,
   input  logic                rst,
   instr_fetch_unit_if.master  bus
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]         fetch_count,
   output logic [31:0]         stall_count
`endif
);

   ifu_state_e  r_state;
   logic [31:0] r_fetch_pc;
   logic [31:0] r_imem_addr;
   logic        r_imem_req;
   logic [31:0] r_ins;
   logic [31:0] r_pc;
   logic        r_ins_valid;
   logic        r_halted;
   logic        r_squash;
   logic [31:0] w_next_pc;

   assign w_next_pc = r_pc + PC_STEP;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IFU_IDLE;
         r_fetch_pc  <= RESET_PC;
         r_imem_addr <= RESET_PC;
         r_imem_req  <= 1'b0;
         r_ins       <= 32'd0;
         r_pc        <= 32'd0;
         r_ins_valid <= 1'b0;
         r_halted    <= 1'b0;
         r_squash    <= 1'b0;
      end else begin
         case (r_state)
            IFU_IDLE: begin
               r_state     <= IFU_FETCH;
               r_imem_req  <= 1'b1;
               r_imem_addr <= r_fetch_pc;
            end
            IFU_FETCH: begin
               // imem_addr holds the in-flight address until ack, even across a redirect
               if (bus.redirect_en) begin
                  r_fetch_pc <= bus.redirect_pc;
                  if (bus.imem_ack) begin
                     r_imem_addr <= bus.redirect_pc;
                     r_squash    <= 1'b0;
                  end else begin
                     r_squash    <= 1'b1;
                  end
               end else if (bus.imem_ack) begin
                  if (r_squash) begin
                     r_squash    <= 1'b0;
                     r_imem_addr <= r_fetch_pc;
                  end else begin
                     r_ins       <= bus.imem_rdata;
                     r_pc        <= r_fetch_pc;
                     r_ins_valid <= 1'b1;
                     r_imem_req  <= 1'b0;
                     r_state     <= IFU_HOLD;
                  end
               end
            end
            IFU_HOLD: begin
               // redirect voids a same-cycle transfer, including one of a HALT
               if (bus.redirect_en) begin
                  r_fetch_pc  <= bus.redirect_pc;
                  r_imem_addr <= bus.redirect_pc;
                  r_imem_req  <= 1'b1;
                  r_ins_valid <= 1'b0;
                  r_state     <= IFU_FETCH;
               end else if (bus.ins_ready) begin
                  r_ins_valid <= 1'b0;
                  if (is_halt(r_ins[31:26])) begin
                     r_halted <= 1'b1;
                     r_state  <= IFU_HALT;
                  end else begin
                     r_fetch_pc  <= w_next_pc;
                     r_imem_addr <= w_next_pc;
                     r_imem_req  <= 1'b1;
                     r_state     <= IFU_FETCH;
                  end
               end
            end
            IFU_HALT: begin
            end
            default: r_state <= IFU_IDLE;
         endcase
      end
   end

   assign bus.imem_req  = r_imem_req;
   assign bus.imem_addr = r_imem_addr;
   assign bus.ins       = r_ins;
   assign bus.PC        = r_pc;
   assign bus.ins_valid = r_ins_valid;
   assign bus.halted    = r_halted;

`ifdef IFU_PERF_CNT_EN
   logic w_transfer;
   logic w_stall;

   assign w_transfer = r_ins_valid && bus.ins_ready && !bus.redirect_en;
   assign w_stall    = (r_ins_valid && !bus.ins_ready) || (r_imem_req && !bus.imem_ack);

   ifu_perf_counters u_perf (
      .clk           (clk),
      .rst           (rst),
      .i_transfer    (w_transfer),
      .i_stall       (w_stall),
      .o_fetch_count (fetch_count),
      .o_stall_count (stall_count)
   );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a latency-configurable imem model
module tb_instr_fetch_unit;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   int   mem_lat;
   logic [31:0] halt_addr;
   logic [31:0] exp_q[$];

   instr_fetch_unit_if bus();

`ifdef IFU_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   instr_fetch_unit #(.RESET_PC(32'h0), .PC_STEP(32'd1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef IFU_PERF_CNT_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a == halt_addr) return 32'h90000000;
      return 32'h04210005 + (a << 8);
   endfunction

   // memory: acks after mem_lat waiting cycles, checks address stability while waiting
   initial begin
      int          wcnt;
      logic [31:0] req_addr;
      wcnt = 0;
      req_addr = 32'd0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = 32'd0;
      forever begin
         @(posedge clk); #1;
         bus.imem_ack = 1'b0;
         if (rst || !bus.imem_req) begin
            wcnt = 0;
         end else begin
            if (wcnt == 0) begin
               req_addr = bus.imem_addr;
            end else begin
               n_cmp++;
               if (bus.imem_addr !== req_addr) begin
                  n_bad++;
                  $display("FAIL addr_stable: imem_addr=%h expected %h", bus.imem_addr, req_addr);
               end
            end
            if (wcnt >= mem_lat) begin
               bus.imem_ack = 1'b1;
               bus.imem_rdata = word_at(bus.imem_addr);
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end
      end
   end

   // transfer monitor: every accepted instruction must match the next expected PC
   always @(negedge clk) begin
      if (!rst && bus.ins_valid && bus.ins_ready && !bus.redirect_en) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_transfer: PC=%h ins=%h with none expected", bus.PC, bus.ins);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (bus.PC !== e || bus.ins !== word_at(e)) begin
               n_bad++;
               $display("FAIL transfer: PC=%h ins=%h expected PC=%h ins=%h", bus.PC, bus.ins, e, word_at(e));
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      bus.ins_ready = 1'b0;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = 32'd0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain_timeout: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: %b expected 0", bus.imem_req); end
      n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: %h expected 0", bus.imem_addr); end
      n_cmp++; if (bus.ins !== 32'h0) begin n_bad++; $display("FAIL rst_ins: %h expected 0", bus.ins); end
      n_cmp++; if (bus.PC !== 32'h0) begin n_bad++; $display("FAIL rst_pc: %h expected 0", bus.PC); end
      n_cmp++; if (bus.ins_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: %b expected 0", bus.ins_valid); end
      n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL rst_halted: %b expected 0", bus.halted); end
`ifdef IFU_PERF_CNT_EN
      n_cmp++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin
         n_bad++; $display("FAIL rst_perf: %h %h expected 0 0", fetch_count, stall_count);
      end
`endif
   endtask

   task automatic test_first_fetch();
      mem_lat = 0;
      do_reset();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
      bus.ins_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL ff_req_c0: %b expected 0", bus.imem_req); end
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.ins_valid !== 1'b0) begin
         n_bad++; $display("FAIL ff_req_c1: req=%b addr=%h valid=%b expected 1 0 0", bus.imem_req, bus.imem_addr, bus.ins_valid);
      end
      @(negedge clk);
      n_cmp++; if (bus.ins_valid !== 1'b1 || bus.PC !== 32'h0 || bus.ins !== 32'h04210005) begin
         n_bad++; $display("FAIL ff_valid_c2: valid=%b PC=%h ins=%h expected 1 0 04210005", bus.ins_valid, bus.PC, bus.ins);
      end
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h1) begin
         n_bad++; $display("FAIL ff_next_addr: req=%b addr=%h expected 1 1", bus.imem_req, bus.imem_addr);
      end
      wait_drain(40);
      @(posedge clk); #1 bus.ins_ready = 1'b0;
   endtask

   task automatic test_stall();
      int k;
      mem_lat = 3;
      do_reset();
      for (int i = 0; i < 3; i++) exp_q.push_back(32'(i));
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.ins_valid && k < 30);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (bus.ins_valid !== 1'b1 || bus.PC !== 32'h0 || bus.ins !== word_at(32'h0)) begin
            n_bad++; $display("FAIL stall_hold: valid=%b PC=%h ins=%h expected 1 0 %h", bus.ins_valid, bus.PC, bus.ins, word_at(32'h0));
         end
         @(negedge clk);
      end
      @(posedge clk); #1 bus.ins_ready = 1'b1;
      wait_drain(60);
      @(posedge clk); #1 bus.ins_ready = 1'b0;
   endtask

   task automatic test_redirect_outstanding();
      int k;
      mem_lat = 3;
      do_reset();
      exp_q.push_back(32'h40);
      exp_q.push_back(32'h41);
      bus.ins_ready = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (!(bus.imem_req && !bus.imem_ack) && k < 20);
      @(posedge clk); #1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h40;
      @(posedge clk); #1;
      bus.redirect_en = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.imem_ack && k < 20);
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin
         n_bad++; $display("FAIL redir_addr: req=%b addr=%h expected 1 00000040", bus.imem_req, bus.imem_addr);
      end
      wait_drain(60);
      @(posedge clk); #1 bus.ins_ready = 1'b0;
   endtask

   task automatic test_redirect_halt();
      int k;
      mem_lat = 0;
      halt_addr = 32'h2;
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      bus.ins_ready = 1'b1;
      wait_drain(40);
      @(posedge clk); #1 bus.ins_ready = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.ins_valid && k < 20);
      n_cmp++; if (bus.PC !== 32'h2 || bus.ins !== 32'h90000000) begin
         n_bad++; $display("FAIL rh_held: PC=%h ins=%h expected 2 90000000", bus.PC, bus.ins);
      end
      exp_q.push_back(32'h80);
      @(posedge clk); #1;
      bus.ins_ready = 1'b1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h80;
      @(posedge clk); #1;
      bus.redirect_en = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.halted !== 1'b0 || bus.ins_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h80) begin
         n_bad++; $display("FAIL rh_resume: halted=%b valid=%b req=%b addr=%h expected 0 0 1 00000080",
                           bus.halted, bus.ins_valid, bus.imem_req, bus.imem_addr);
      end
      wait_drain(40);
      @(posedge clk); #1 bus.ins_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL rh_halted: %b expected 0", bus.halted); end
      halt_addr = 32'h77777777;
   endtask

   task automatic test_halt();
      mem_lat = 0;
      halt_addr = 32'h1;
      do_reset();
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h1);
      bus.ins_ready = 1'b1;
      wait_drain(40);
      @(negedge clk);
      n_cmp++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.ins_valid !== 1'b0) begin
         n_bad++; $display("FAIL halt_enter: halted=%b req=%b valid=%b expected 1 0 0", bus.halted, bus.imem_req, bus.ins_valid);
      end
      @(posedge clk); #1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'h40;
      @(posedge clk); #1;
      bus.redirect_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.halted !== 1'b1 || bus.imem_req !== 1'b0 || bus.ins_valid !== 1'b0) begin
            n_bad++; $display("FAIL halt_stay: halted=%b req=%b valid=%b expected 1 0 0", bus.halted, bus.imem_req, bus.ins_valid);
         end
      end
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.halted !== 1'b0) begin n_bad++; $display("FAIL halt_reset: %b expected 0", bus.halted); end
      bus.ins_ready = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      halt_addr = 32'h77777777;
   endtask

   task automatic test_wrap();
      int k;
      mem_lat = 0;
      do_reset();
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.ins_valid && k < 20);
      @(posedge clk); #1;
      bus.redirect_en = 1'b1;
      bus.redirect_pc = 32'hFFFFFFFF;
      @(posedge clk); #1;
      bus.redirect_en = 1'b0;
      k = 0;
      do begin @(negedge clk); k++; end while (!bus.ins_valid && k < 20);
      n_cmp++; if (bus.PC !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL wrap_pc: %h expected ffffffff", bus.PC); end
      exp_q.push_back(32'hFFFFFFFF);
      exp_q.push_back(32'h0);
      @(posedge clk); #1 bus.ins_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
         n_bad++; $display("FAIL wrap_addr: req=%b addr=%h expected 1 0", bus.imem_req, bus.imem_addr);
      end
      wait_drain(40);
      @(posedge clk); #1 bus.ins_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;
      mem_lat = 0;
      halt_addr = 32'h77777777;
      rst = 1'b1;
      bus.ins_ready = 1'b0;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = 32'd0;
      test_reset();
      test_first_fetch();
      test_stall();
      test_redirect_outstanding();
      test_redirect_halt();
      test_halt();
      test_wrap();
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
